// File: rtl/fir_stream_checker_if.sv
// Stream port bundle for fir_stream_checker.
//   Golden side : EXP_VIN/EXP_DIN in, EXP_RDY out (valid/ready).
//   Filter side : VIN/DIN in (no backpressure), END_SIM level in.
//   Verdict     : ERR pulse, ERR_CNT, SAMPLE_CNT, UNDERFLOW, DONE, PASS out.
// master = producer/bench side, slave = the checker.
// NB and CNT_W must match the parameters of the checker instance.
interface fir_stream_checker_if #(
  parameter int NB    = 9,
  parameter int CNT_W = 16
);
  logic             EXP_VIN;
  logic [NB-1:0]    EXP_DIN;
  logic             EXP_RDY;
  logic             VIN;
  logic [NB-1:0]    DIN;
  logic             END_SIM;
  logic             ERR;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] SAMPLE_CNT;
  logic             UNDERFLOW;
  logic             DONE;
  logic             PASS;

  modport master (
    output EXP_VIN, EXP_DIN, VIN, DIN, END_SIM,
    input  EXP_RDY, ERR, ERR_CNT, SAMPLE_CNT, UNDERFLOW, DONE, PASS
  );

  modport slave (
    input  EXP_VIN, EXP_DIN, VIN, DIN, END_SIM,
    output EXP_RDY, ERR, ERR_CNT, SAMPLE_CNT, UNDERFLOW, DONE, PASS
  );
endinterface

// File: rtl/fir_stream_checker.sv
// fir_stream_checker: receive-side checker for the FIR output stream.
// Golden samples arrive early over a valid/ready port and wait in a small
// FIFO. Each filter-valid sample pops one golden word and is compared
// bitwise; mismatches and underflows pulse ERR and bump ERR_CNT. After
// END_SIM the checker drains (bounded by TIMEOUT cycles) and latches a
// sticky DONE/PASS verdict that only reset clears.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  fir_stream_checker_if.slave (golden port, filter port, verdict)
module fir_stream_checker #(
  parameter int NB      = 9,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  fir_stream_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {RUN, DRAIN, REPORT} state_t;

  state_t           state, state_nxt;
  logic [NB-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, active, exp_rdy;
  logic             push, check, pop, mismatch;
  logic [CNT_W-1:0] err_cnt, err_cnt_nxt, sample_cnt, sample_cnt_nxt;
  logic             err_q, underflow, underflow_nxt;
  logic             done_q, done_nxt, pass_q, pass_nxt;
  logic [DW-1:0]    drain_cnt, drain_cnt_nxt;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign active  = (state != REPORT);
  assign exp_rdy = !full && active;

  assign push     = bus.EXP_VIN && exp_rdy;
  assign check    = bus.VIN && active;
  assign pop      = check && !empty;
  // No bypass: an empty FIFO is an underflow even if a push lands this cycle.
  assign mismatch = check && (empty || (bus.DIN != mem[rd_ptr[AW-1:0]]));

  always_comb begin
    err_cnt_nxt    = err_cnt;
    sample_cnt_nxt = sample_cnt;
    if (mismatch && err_cnt != CNT_MAX)  err_cnt_nxt    = err_cnt + 1'b1;
    if (check && sample_cnt != CNT_MAX)  sample_cnt_nxt = sample_cnt + 1'b1;
    underflow_nxt = underflow || (check && empty);
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    done_nxt      = done_q;
    pass_nxt      = pass_q;
    case (state)
      RUN: begin
        if (bus.END_SIM) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        drain_cnt_nxt = drain_cnt + 1'b1;
        if (empty) begin
          // Verdict includes any error raised at this same edge.
          state_nxt = REPORT;
          done_nxt  = 1'b1;
          pass_nxt  = (err_cnt_nxt == '0) && !underflow_nxt;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt = REPORT;
          done_nxt  = 1'b1;
          pass_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_q      <= 1'b0;
      err_cnt    <= '0;
      sample_cnt <= '0;
      underflow  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      err_q      <= mismatch;
      err_cnt    <= err_cnt_nxt;
      sample_cnt <= sample_cnt_nxt;
      underflow  <= underflow_nxt;
      done_q     <= done_nxt;
      pass_q     <= pass_nxt;
      drain_cnt  <= drain_cnt_nxt;
    end
  end

  // Storage needs no reset; occupancy lives in the pointers.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.EXP_DIN;
  end

  assign bus.EXP_RDY    = exp_rdy;
  assign bus.ERR        = err_q;
  assign bus.ERR_CNT    = err_cnt;
  assign bus.SAMPLE_CNT = sample_cnt;
  assign bus.UNDERFLOW  = underflow;
  assign bus.DONE       = done_q;
  assign bus.PASS       = pass_q;
endmodule

// File: tb/tb_fir_stream_checker.sv
// Bench for fir_stream_checker: directed scenarios plus random rounds, all
// checked cycle by cycle against a queue-based reference model.
module tb_fir_stream_checker;
  localparam int NB      = 9;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;   // narrow so saturation is reachable
  localparam int TIMEOUT = 64;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  fir_stream_checker_if #(.NB(NB), .CNT_W(CNT_W)) bus ();

  fir_stream_checker #(
    .NB(NB), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: golden queue, counters, verdict.
  logic [NB-1:0] mq[$];
  int m_err_cnt, m_samp, m_dcyc;
  bit m_uf, m_err, m_done, m_pass, m_drain;

  function automatic void model_reset();
    mq.delete();
    m_err_cnt = 0; m_samp = 0; m_dcyc = 0;
    m_uf = 0; m_err = 0; m_done = 0; m_pass = 0; m_drain = 0;
  endfunction

  function automatic bit model_rdy();
    return (mq.size() < DEPTH) && !m_done;
  endfunction

  function automatic void model_edge(input bit vin, input logic [NB-1:0] din,
                                     input bit evin, input logic [NB-1:0] edin,
                                     input bit endsim);
    bit was_empty;
    bit rdy;
    was_empty = (mq.size() == 0);
    rdy       = model_rdy();
    m_err     = 0;
    if (!m_done) begin
      if (vin) begin
        if (m_samp < CNT_MAX) m_samp++;
        if (was_empty) begin
          m_err = 1; m_uf = 1;
        end else begin
          if (mq[0] != din) m_err = 1;
          void'(mq.pop_front());
        end
        if (m_err && m_err_cnt < CNT_MAX) m_err_cnt++;
      end
      if (m_drain) begin
        if (was_empty) begin
          m_done = 1; m_pass = (m_err_cnt == 0) && !m_uf;
        end else if (m_dcyc == TIMEOUT - 1) begin
          m_done = 1; m_pass = 0;
        end else m_dcyc++;
      end else if (endsim) begin
        m_drain = 1; m_dcyc = 0;
      end
    end
    if (rdy && evin) mq.push_back(edin);
  endfunction

  // One clock: drive at negedge, check EXP_RDY before the edge, outputs after.
  task automatic step(input bit vin, input logic [NB-1:0] din,
                      input bit evin, input logic [NB-1:0] edin, input bit endsim);
    bus.VIN = vin; bus.DIN = din;
    bus.EXP_VIN = evin; bus.EXP_DIN = edin; bus.END_SIM = endsim;
    #1;
    chk("exp_rdy", 32'(bus.EXP_RDY), 32'(model_rdy()));
    model_edge(vin, din, evin, edin, endsim);
    @(posedge CLK); #1;
    chk("err",        32'(bus.ERR),        32'(m_err));
    chk("err_cnt",    32'(bus.ERR_CNT),    m_err_cnt);
    chk("sample_cnt", 32'(bus.SAMPLE_CNT), m_samp);
    chk("underflow",  32'(bus.UNDERFLOW),  32'(m_uf));
    chk("done",       32'(bus.DONE),       32'(m_done));
    if (m_done) chk("pass", 32'(bus.PASS), 32'(m_pass));
    @(negedge CLK);
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0);
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must clear at once.
  task automatic async_reset();
    bus.VIN = 0; bus.DIN = '0; bus.EXP_VIN = 0; bus.EXP_DIN = '0; bus.END_SIM = 0;
    #3 RST = 1'b1;
    #1;
    chk("rst_err",       32'(bus.ERR),        0);
    chk("rst_err_cnt",   32'(bus.ERR_CNT),    0);
    chk("rst_sample_cnt",32'(bus.SAMPLE_CNT), 0);
    chk("rst_underflow", 32'(bus.UNDERFLOW),  0);
    chk("rst_done",      32'(bus.DONE),       0);
    chk("rst_pass",      32'(bus.PASS),       0);
    chk("rst_exp_rdy",   32'(bus.EXP_RDY),    1);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Hold END_SIM and optionally feed matching samples until DONE, bounded.
  task automatic drain_to_done(input bit feed);
    int k;
    bit v;
    k = 0;
    while (!bus.DONE && k < 4 * TIMEOUT) begin
      v = feed && (mq.size() > 0);
      step(v, v ? mq[0] : '0, 0, '0, 1);
      k++;
    end
    chk("drain_done", 32'(bus.DONE), 1);
  endtask

  initial begin
    int cyc;
    logic [NB-1:0] d;
    bit v;
    bus.VIN = 0; bus.DIN = '0; bus.EXP_VIN = 0; bus.EXP_DIN = '0; bus.END_SIM = 0;
    model_reset();
    @(negedge CLK);
    async_reset();

    // Matching stream.
    step(0, '0, 1, 9'h001, 0);
    step(0, '0, 1, 9'h1FF, 0);
    step(0, '0, 1, 9'h100, 0);
    step(1, 9'h001, 0, '0, 0);
    step(1, 9'h1FF, 0, '0, 0);
    step(1, 9'h100, 0, '0, 0);
    chk("match_samples", 32'(bus.SAMPLE_CNT), 3);
    chk("match_errs",    32'(bus.ERR_CNT),    0);
    step(0, '0, 0, '0, 1);
    idle();
    chk("match_done", 32'(bus.DONE), 1);
    chk("match_pass", 32'(bus.PASS), 1);
    step(1, 9'h055, 1, 9'h055, 1);   // ignored once reporting
    chk("report_frozen", 32'(bus.SAMPLE_CNT), 3);

    // Single mismatch.
    async_reset();
    step(0, '0, 1, 9'h0A5, 0);
    step(0, '0, 1, 9'h05A, 0);
    step(1, 9'h0A5, 0, '0, 0);
    chk("mm_no_err_first", 32'(bus.ERR), 0);
    step(1, 9'h05B, 0, '0, 0);
    chk("mm_err_pulse", 32'(bus.ERR), 1);
    idle();
    chk("mm_err_clear", 32'(bus.ERR), 0);
    chk("mm_err_cnt", 32'(bus.ERR_CNT), 1);
    drain_to_done(1);
    chk("mm_pass", 32'(bus.PASS), 0);

    // Full / backpressure, then pops with concurrent pushes across the wrap.
    async_reset();
    for (int i = 0; i < 10; i++) step(0, '0, 1, NB'(i), 0);
    chk("full_rdy_low", 32'(bus.EXP_RDY), 0);
    for (int i = 0; i < 8; i++) step(1, NB'(i), 1, NB'(100 + i), 0);
    for (int i = 1; i < 8; i++) step(1, NB'(100 + i), 0, '0, 0);
    chk("wrap_errs", 32'(bus.ERR_CNT), 0);
    drain_to_done(1);
    chk("wrap_pass", 32'(bus.PASS), 1);

    // Underflow concurrent with the first push.
    async_reset();
    step(1, 9'h003, 1, 9'h003, 0);
    chk("uf_flag", 32'(bus.UNDERFLOW), 1);
    chk("uf_errs", 32'(bus.ERR_CNT), 1);
    chk("uf_kept", 32'(bus.EXP_RDY), 1);
    step(0, '0, 0, '0, 1);
    step(1, 9'h003, 0, '0, 0);       // stored word still matches
    chk("uf_kept_match", 32'(bus.ERR), 0);
    idle();
    chk("uf_done", 32'(bus.DONE), 1);
    chk("uf_pass", 32'(bus.PASS), 0);

    // Drain timeout.
    async_reset();
    step(0, '0, 1, 9'h011, 0);
    step(0, '0, 1, 9'h022, 0);
    step(0, '0, 0, '0, 1);
    cyc = 0;
    while (!bus.DONE && cyc < 4 * TIMEOUT) begin
      idle();
      cyc++;
    end
    chk("timeout_latency", cyc, TIMEOUT);
    chk("timeout_pass", 32'(bus.PASS), 0);
    chk("timeout_rdy", 32'(bus.EXP_RDY), 0);

    // Error counter saturation.
    async_reset();
    step(0, '0, 1, 9'h000, 0);
    for (int i = 0; i < 20; i++) step(1, 9'h001, 1, 9'h000, 0);
    chk("err_saturated", 32'(bus.ERR_CNT), CNT_MAX);
    chk("samp_saturated", 32'(bus.SAMPLE_CNT), CNT_MAX);

    // Reset in the middle of a drain.
    async_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 1, NB'(7 * i + 1), 0);
    step(0, '0, 0, '0, 1);
    idle();
    idle();
    async_reset();
    step(0, '0, 1, 9'h0AA, 0);
    step(0, '0, 1, 9'h155, 0);
    step(1, 9'h0AA, 0, '0, 0);
    step(1, 9'h155, 0, '0, 0);
    drain_to_done(0);
    chk("rst_drain_pass", 32'(bus.PASS), 1);

    // Random rounds.
    for (int r = 0; r < 8; r++) begin
      async_reset();
      cyc = $urandom_range(60, 20);
      for (int c = 0; c < cyc; c++) begin
        v = ($urandom_range(2, 0) == 0);
        if (mq.size() > 0 && $urandom_range(7, 0) != 0) d = mq[0];
        else d = NB'($urandom);
        step(v, d, bit'($urandom_range(1, 0)), NB'($urandom), c == cyc - 1);
      end
      drain_to_done(r % 3 != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
